sdram_port_sched: RTL and testbench

SDRAM_PORT_SCHED -- requirements
Module: sdram_port_sched

---
 rtl/sdram_sched_pkg.sv | 25 ++
 rtl/sdram_rr_arb.sv | 43 ++++
 rtl/sdram_port_sched.sv | 153 +++++++++++++++
 tb/tb_sdram_port_sched.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_sched_pkg.sv
// Shared types for the SDRAM port scheduler: FSM states, client index, strobe bundle.
// Pure declarations; no latency or backpressure of its own.
// Client count is fixed at four in this release.
package sdram_sched_pkg;

    localparam int NCLI = 4;

    typedef logic [1:0] cli_idx_t;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        ISSUE,
        ACKW,
        DONEW,
        GAP
    } sched_state_t;

    typedef struct packed {
        logic rd;
        logic wrl;
        logic wrh;
    } strobe_t;

endpackage

// File: rtl/sdram_rr_arb.sv
// Four-way combinational grant with a registered last_grant pointer (reset to 3).
// Zero-latency grant; the pointer only moves when the scheduler takes the grant (advance).
// Build option: SDRAM_SCHED_FIXED_PRIO_EN selects fixed priority, client 0 highest.
module sdram_rr_arb
    import sdram_sched_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [NCLI-1:0] req,
    input  logic            advance,
    output cli_idx_t        grant,
    output logic            grant_vld
);

    cli_idx_t last_grant;
    cli_idx_t idx;

    always_comb begin
        grant     = '0;
        idx       = '0;
        grant_vld = |req;
`ifdef SDRAM_SCHED_FIXED_PRIO_EN
        for (int i = NCLI - 1; i >= 0; i--) begin
            idx = cli_idx_t'(i);
            if (req[idx]) grant = idx;
        end
`else
        // Walk from farthest to nearest so the client right after last_grant wins.
        for (int i = NCLI; i >= 1; i--) begin
            idx = last_grant + cli_idx_t'(i);
            if (req[idx]) grant = idx;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset)
            last_grant <= cli_idx_t'(3);
        else if (advance)
            last_grant <= grant;
    end

endmodule

// File: rtl/sdram_port_sched.sv
// Schedules four level-request clients onto one edge-strobed SDRAM controller port.
// Latency: cl_req rise to cl_rdy = 4 + controller busy cycles; one transaction in flight.
// Backpressure: clients hold cl_req until their cl_rdy pulse. Option: SDRAM_SCHED_FIXED_PRIO_EN.
module sdram_port_sched #(
    parameter int ACK_TMO = 15,
    parameter int NCLI    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NCLI-1:0]       cl_req,
    input  logic [NCLI-1:0]       cl_we,
    input  logic [NCLI-1:0][1:0]  cl_be,
    input  logic [NCLI-1:0][23:0] cl_addr,
    input  logic [NCLI-1:0][15:0] cl_din,
    output logic [15:0]           cl_dout,
    output logic [NCLI-1:0]       cl_rdy,
    output logic [23:0]           mem_addr,
    output logic [15:0]           mem_din,
    output logic                  mem_rd,
    output logic                  mem_wrl,
    output logic                  mem_wrh,
    input  logic [15:0]           mem_dout,
    input  logic                  mem_busy,
    output logic                  tmo_err
);

    import sdram_sched_pkg::*;

    localparam int            TW       = $clog2(ACK_TMO + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TMO - 1);

    sched_state_t    state, state_nxt;
    strobe_t         strb, strb_new;
    cli_idx_t        grant, gnt_q;
    logic            gnt_vld, arb_adv, rdy_set, rd_done, tmo_hit;
    logic            we_q;
    logic [1:0]      be_q;
    logic [TW-1:0]   tmo_cnt;
    logic [NCLI-1:0] req_eff;

    // A client whose completion is pulsing this cycle still shows its request.
    assign req_eff = cl_req & ~cl_rdy;

    assign mem_rd  = strb.rd;
    assign mem_wrl = strb.wrl;
    assign mem_wrh = strb.wrh;

    sdram_rr_arb u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (req_eff),
        .advance   (arb_adv),
        .grant     (grant),
        .grant_vld (gnt_vld)
    );

    always_comb begin
        strb_new     = '0;
        strb_new.rd  = ~cl_we[grant];
        strb_new.wrl = cl_we[grant] & cl_be[grant][0];
        strb_new.wrh = cl_we[grant] & cl_be[grant][1];
    end

    always_comb begin
        state_nxt = state;
        arb_adv   = 1'b0;
        rdy_set   = 1'b0;
        rd_done   = 1'b0;
        tmo_hit   = 1'b0;
        case (state)
            IDLE:  if (|req_eff) state_nxt = ARB;
            ARB: begin
                if (gnt_vld) begin
                    arb_adv   = 1'b1;
                    state_nxt = ISSUE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            ISSUE: begin
                // A write with no byte lanes has nothing to send to the controller.
                if (we_q && be_q == 2'b00) begin
                    rdy_set   = 1'b1;
                    state_nxt = GAP;
                end else begin
                    state_nxt = ACKW;
                end
            end
            ACKW: begin
                if (mem_busy) begin
                    state_nxt = DONEW;
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_hit   = 1'b1;
                    rdy_set   = 1'b1;
                    state_nxt = GAP;
                end
            end
            DONEW: begin
                if (!mem_busy) begin
                    rdy_set   = 1'b1;
                    rd_done   = ~we_q;
                    state_nxt = GAP;
                end
            end
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            strb     <= '0;
            gnt_q    <= '0;
            we_q     <= 1'b0;
            be_q     <= 2'b00;
            mem_addr <= '0;
            mem_din  <= '0;
            cl_rdy   <= '0;
            cl_dout  <= '0;
            tmo_err  <= 1'b0;
            tmo_cnt  <= '0;
        end else begin
            cl_rdy <= '0;
            if (arb_adv) begin
                gnt_q    <= grant;
                we_q     <= cl_we[grant];
                be_q     <= cl_be[grant];
                mem_addr <= cl_addr[grant];
                mem_din  <= cl_din[grant];
                strb     <= strb_new;
            end else if (state_nxt != ISSUE && state_nxt != ACKW) begin
                strb <= '0;
            end
            if (rdy_set)
                cl_rdy[gnt_q] <= 1'b1;
            if (tmo_hit) begin
                cl_dout <= 16'hFFFF;
                tmo_err <= 1'b1;
            end else if (rd_done) begin
                cl_dout <= mem_dout;
            end
            tmo_cnt <= (state == ACKW) ? tmo_cnt + 1'b1 : '0;
        end
    end

endmodule

// File: tb/tb_sdram_port_sched.sv
// Directed bench for sdram_port_sched with a small edge-sensing controller model.
module tb_sdram_port_sched;

    logic             clk = 1'b0;
    logic             reset;
    logic [3:0]       cl_req;
    logic [3:0]       cl_we;
    logic [7:0]       cl_be;
    logic [3:0][23:0] cl_addr;
    logic [3:0][15:0] cl_din;
    logic [15:0]      cl_dout;
    logic [3:0]       cl_rdy;
    logic [23:0]      mem_addr;
    logic [15:0]      mem_din;
    logic             mem_rd, mem_wrl, mem_wrh;
    logic [15:0]      mem_dout;
    logic             mem_busy;
    logic             tmo_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sdram_port_sched dut (
        .clk      (clk),
        .reset    (reset),
        .cl_req   (cl_req),
        .cl_we    (cl_we),
        .cl_be    (cl_be),
        .cl_addr  (cl_addr),
        .cl_din   (cl_din),
        .cl_dout  (cl_dout),
        .cl_rdy   (cl_rdy),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_rd   (mem_rd),
        .mem_wrl  (mem_wrl),
        .mem_wrh  (mem_wrh),
        .mem_dout (mem_dout),
        .mem_busy (mem_busy),
        .tmo_err  (tmo_err)
    );

    // Controller model: one cycle after a strobe rises, hold busy for busy_len cycles.
    int busy_len;
    bit never_ack;
    int busy_left  = 0;
    bit start_pend = 0;
    bit prev_any = 0, prev_rd = 0, prev_wrl = 0, prev_wrh = 0;
    int n_rd = 0, n_wrl = 0, n_wrh = 0, low_run = 0, rd_gap = 0;

    always @(negedge clk) begin
        if (busy_left > 0) busy_left--;
        if (start_pend) begin
            start_pend = 0;
            if (!never_ack) busy_left = busy_len;
        end
        mem_busy = (busy_left > 0);
        if ((mem_rd | mem_wrl | mem_wrh) && !prev_any) start_pend = 1;
        if (mem_rd && !prev_rd) begin
            n_rd++;
            rd_gap = low_run;
        end
        if (mem_wrl && !prev_wrl) n_wrl++;
        if (mem_wrh && !prev_wrh) n_wrh++;
        low_run  = mem_rd ? 0 : low_run + 1;
        prev_any = mem_rd | mem_wrl | mem_wrh;
        prev_rd  = mem_rd;
        prev_wrl = mem_wrl;
        prev_wrh = mem_wrh;
    end

    int order[$];
    int rdy_cnt[4];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_cli(input int i, input logic we, input logic [1:0] be,
                           input logic [23:0] addr, input logic [15:0] din);
        cl_we[i]          = we;
        cl_be[2*i +: 2]   = be;
        cl_addr[i]        = addr;
        cl_din[i]         = din;
    endtask

    task automatic clear_log();
        order.delete();
        for (int i = 0; i < 4; i++) rdy_cnt[i] = 0;
    endtask

    function automatic int order_code();
        int c = 0;
        foreach (order[k]) c = (c << 4) | order[k];
        return c;
    endfunction

    function automatic int rdy_total();
        return rdy_cnt[0] + rdy_cnt[1] + rdy_cnt[2] + rdy_cnt[3];
    endfunction

    task automatic log_rdy();
        for (int i = 0; i < 4; i++)
            if (cl_rdy[i]) begin
                order.push_back(i);
                rdy_cnt[i]++;
            end
    endtask

    // Serve pending requests, dropping each one on its cl_rdy; lat = first completion cycle.
    task automatic run_txn(input int budget, input int tail, output int lat);
        int n = 0;
        lat = -1;
        while (cl_req != 4'b0000 && n < budget) begin
            @(negedge clk);
            n++;
            if (cl_rdy != 4'b0000) begin
                if (lat < 0) lat = n;
                log_rdy();
                cl_req = cl_req & ~cl_rdy;
            end
        end
        if (cl_req != 4'b0000) chk("txn_budget", 32'(cl_req), 32'h0);
        for (int t = 0; t < tail; t++) begin
            @(negedge clk);
            log_rdy();
        end
    endtask

    initial begin
        int lat, lat2, e_rd, e_wrl, e_wrh, seen;
        reset     = 1'b1;
        cl_req    = '0;
        cl_we     = '0;
        cl_be     = '0;
        cl_addr   = '0;
        cl_din    = '0;
        mem_dout  = '0;
        busy_len  = 2;
        never_ack = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        chk("rst_cl_rdy",   32'(cl_rdy), 32'h0);
        chk("rst_cl_dout",  32'(cl_dout), 32'h0);
        chk("rst_tmo_err",  32'(tmo_err), 32'h0);
        chk("rst_strobes",  32'({mem_rd, mem_wrl, mem_wrh}), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_mem_din",  32'(mem_din), 32'h0);

        // All four clients at once, twice: round-robin from client 0 both times.
        for (int i = 0; i < 4; i++) set_cli(i, 1'b0, 2'b00, 24'(i * 16), 16'h0000);
        clear_log();
        cl_req = 4'hF;
        run_txn(200, 3, lat);
        chk("rr_order_1",   32'(order_code()), 32'h0123);
        chk("rr_first_lat", 32'(lat), 32'd6);
        chk("rr_rdy_total", 32'(rdy_total()), 32'd4);
        clear_log();
        cl_req = 4'hF;
        run_txn(200, 3, lat);
        chk("rr_order_2",   32'(order_code()), 32'h0123);

        // Single read, client 2, busy 6 cycles.
        busy_len = 6;
        mem_dout = 16'hBEEF;
        set_cli(2, 1'b0, 2'b00, 24'h001234, 16'h0000);
        e_rd = n_rd;
        clear_log();
        cl_req = 4'b0100;
        run_txn(100, 4, lat);
        chk("rd_rdy2",      32'(rdy_cnt[2]), 32'd1);
        chk("rd_rdy_other", 32'(rdy_total() - rdy_cnt[2]), 32'd0);
        chk("rd_dout",      32'(cl_dout), 32'hBEEF);
        chk("rd_edges",     32'(n_rd - e_rd), 32'd1);
        chk("rd_latency",   32'(lat), 32'd10);
        chk("rd_mem_addr",  32'(mem_addr), 32'h001234);
        chk("rd_no_tmo",    32'(tmo_err), 32'h0);

        // After client 2, clients 0 and 3 together: round-robin serves 3 first.
        busy_len = 2;
        mem_dout = 16'h1111;
        set_cli(0, 1'b0, 2'b00, 24'h000100, 16'h0000);
        set_cli(3, 1'b0, 2'b00, 24'h000300, 16'h0000);
        clear_log();
        cl_req = 4'b1001;
        run_txn(200, 3, lat);
        chk("rr_wrap_order", 32'(order_code()), 32'h30);

        // Write, client 1, high byte only.
        busy_len = 3;
        mem_dout = 16'h7777;
        set_cli(1, 1'b1, 2'b10, 24'h000ABC, 16'h5A5A);
        e_rd = n_rd; e_wrl = n_wrl; e_wrh = n_wrh;
        clear_log();
        cl_req = 4'b0010;
        run_txn(100, 3, lat);
        chk("wr_wrh_edges", 32'(n_wrh - e_wrh), 32'd1);
        chk("wr_wrl_edges", 32'(n_wrl - e_wrl), 32'd0);
        chk("wr_rd_edges",  32'(n_rd - e_rd), 32'd0);
        chk("wr_rdy1",      32'(rdy_cnt[1]), 32'd1);
        chk("wr_latency",   32'(lat), 32'd7);
        chk("wr_mem_din",   32'(mem_din), 32'h5A5A);
        chk("wr_dout_hold", 32'(cl_dout), 32'h1111);

        // Write with no byte enables completes with no strobe at all.
        set_cli(0, 1'b1, 2'b00, 24'h000055, 16'h1234);
        e_rd = n_rd; e_wrl = n_wrl; e_wrh = n_wrh;
        clear_log();
        cl_req = 4'b0001;
        run_txn(100, 3, lat);
        chk("be0_latency", 32'(lat), 32'd3);
        chk("be0_edges",   32'((n_rd - e_rd) + (n_wrl - e_wrl) + (n_wrh - e_wrh)), 32'd0);
        chk("be0_rdy0",    32'(rdy_cnt[0]), 32'd1);

        // Controller never acknowledges: timeout after 15 cycles in ACKW.
        never_ack = 1;
        set_cli(3, 1'b0, 2'b00, 24'h00F00F, 16'h0000);
        clear_log();
        cl_req = 4'b1000;
        run_txn(100, 3, lat);
        never_ack = 0;
        chk("tmo_err",     32'(tmo_err), 32'h1);
        chk("tmo_dout",    32'(cl_dout), 32'hFFFF);
        chk("tmo_rdy3",    32'(rdy_cnt[3]), 32'd1);
        chk("tmo_latency", 32'(lat), 32'd18);
        chk("tmo_rd_low",  32'(mem_rd), 32'h0);

        // Back-to-back reads from client 0.
        busy_len = 2;
        mem_dout = 16'h2222;
        set_cli(0, 1'b0, 2'b00, 24'h000010, 16'h0000);
        e_rd = n_rd;
        clear_log();
        cl_req = 4'b0001;
        run_txn(100, 0, lat);
        cl_req = 4'b0001;
        run_txn(100, 3, lat2);
        chk("b2b_edges",   32'(n_rd - e_rd), 32'd2);
        chk("b2b_low_gap", 32'(rd_gap), 32'd5);
        chk("b2b_lat2",    32'(lat2), 32'd7);
        chk("b2b_rdy0",    32'(rdy_cnt[0]), 32'd2);

        // Reset while waiting for busy to fall, then a normal read.
        busy_len = 8;
        mem_dout = 16'h3333;
        set_cli(1, 1'b0, 2'b00, 24'h000777, 16'h0000);
        clear_log();
        cl_req = 4'b0010;
        repeat (5) begin
            @(negedge clk);
            log_rdy();
        end
        reset  = 1'b1;
        cl_req = 4'b0000;
        @(negedge clk);
        chk("rst_mid_strobes", 32'({mem_rd, mem_wrl, mem_wrh}), 32'h0);
        chk("rst_mid_rdy",     32'(cl_rdy), 32'h0);
        reset = 1'b0;
        seen  = 0;
        repeat (12) begin
            @(negedge clk);
            if (cl_rdy != 4'b0000) seen++;
        end
        chk("rst_mid_no_rdy",   32'(seen + rdy_total()), 32'd0);
        chk("rst_mid_tmo_clr",  32'(tmo_err), 32'h0);
        chk("rst_mid_mem_addr", 32'(mem_addr), 32'h0);
        busy_len = 2;
        mem_dout = 16'h4444;
        clear_log();
        cl_req = 4'b0010;
        run_txn(100, 3, lat);
        chk("post_rst_lat",  32'(lat), 32'd6);
        chk("post_rst_dout", 32'(cl_dout), 32'h4444);
        chk("post_rst_rdy1", 32'(rdy_cnt[1]), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end

endmodule
